// File: rtl/fpmult_pipe.sv
// rtl/fpmult_pipe.sv - four-stage pipelined floating-point multiplier with RNE rounding and exception flags
module fpmult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] dataa,
    input  logic [EXP_W+MAN_W:0] datab,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE     = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E  = '0;

    // tag bits travel alongside the datapath: {sign, nan, invalid, inf, zero}
    localparam int T_SIGN = 4;
    localparam int T_NAN  = 3;
    localparam int T_INV  = 2;
    localparam int T_INF  = 1;
    localparam int T_ZERO = 0;

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv | reset;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [MAN_W:0]   ma, mb;
    logic [4:0]       tag_n;
    logic signed [EW-1:0] e_sum;

    assign ea = dataa[W-2:MAN_W];
    assign eb = datab[W-2:MAN_W];
    assign fa = dataa[MAN_W-1:0];
    assign fb = datab[MAN_W-1:0];

    always_comb begin
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        ma     = a_zero ? '0 : {1'b1, fa};
        mb     = b_zero ? '0 : {1'b1, fb};
        e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        tag_n          = '0;
        tag_n[T_SIGN]  = dataa[W-1] ^ datab[W-1];
        tag_n[T_INV]   = (a_inf & b_zero) | (b_inf & a_zero);
        tag_n[T_NAN]   = a_nan | b_nan | tag_n[T_INV];
        tag_n[T_INF]   = a_inf | b_inf;
        tag_n[T_ZERO]  = a_zero | b_zero;
    end

    logic                 s1_valid, s2_valid, s3_valid;
    logic [4:0]           s1_tag, s2_tag, s3_tag;
    logic [MAN_W:0]       s1_ma, s1_mb;
    logic signed [EW-1:0] s1_e, s2_e, s3_e;
    logic [PW-1:0]        s2_p;
    logic [MAN_W-1:0]     s3_frac;

    logic [MAN_W-1:0]     n_man;
    logic                 n_guard, n_sticky, rnd_up;
    logic signed [EW-1:0] n_e;
    logic [MAN_W:0]       rnd;

    // Normalise the product into [1,2), then round to nearest even on guard/sticky.
    always_comb begin
        if (s2_p[PW-1]) begin
            n_man    = s2_p[PW-2:MAN_W+1];
            n_guard  = s2_p[MAN_W];
            n_sticky = |s2_p[MAN_W-1:0];
            n_e      = s2_e + ONE;
        end else begin
            n_man    = s2_p[PW-3:MAN_W];
            n_guard  = s2_p[MAN_W-1];
            n_sticky = |s2_p[MAN_W-2:0];
            n_e      = s2_e;
        end
        rnd_up = n_guard & (n_sticky | n_man[0]);
        rnd    = {1'b0, n_man} + {{MAN_W{1'b0}}, rnd_up};
    end

    logic [W-1:0] res_n;
    logic [2:0]   flg_n;

    always_comb begin
        res_n = {s3_tag[T_SIGN], s3_e[EXP_W-1:0], s3_frac};
        flg_n = 3'b000;
        if (s3_tag[T_NAN]) begin
            res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flg_n = {s3_tag[T_INV], 2'b00};
        end else if (s3_tag[T_INF]) begin
            res_n = {s3_tag[T_SIGN], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s3_tag[T_ZERO]) begin
            res_n = {s3_tag[T_SIGN], {(W-1){1'b0}}};
        end else if (s3_e >= EXP_MAX) begin
            res_n = {s3_tag[T_SIGN], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_n = 3'b010;
        end else if (s3_e <= ZERO_E) begin
            res_n = {s3_tag[T_SIGN], {(W-1){1'b0}}};
            flg_n = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            result    <= s3_valid ? res_n : '0;
            flags     <= s3_valid ? flg_n : 3'b000;
        end
    end

    // Datapath registers need no reset; their stage valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag  <= tag_n;
            s1_ma   <= ma;
            s1_mb   <= mb;
            s1_e    <= e_sum;
            s2_tag  <= s1_tag;
            s2_p    <= PW'(s1_ma) * PW'(s1_mb);
            s2_e    <= s1_e;
            s3_tag  <= s2_tag;
            s3_frac <= rnd[MAN_W-1:0];
            s3_e    <= n_e + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
        end
    end
endmodule

// File: tb/tb_fpmult_pipe.sv
// tb/tb_fpmult_pipe.sv - scoreboard bench for fpmult_pipe (single and half-width instances)
module tb_fpmult_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] dataa, datab, result;
    logic [2:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_dataa, h_datab, h_result;
    logic [2:0]  h_flags;

    always #5 clk = ~clk;

    fpmult_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fpmult_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .dataa(h_dataa), .datab(h_datab), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    vec_t tv[14];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output side: every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got 0x%0h with no operation outstanding", result);
            end else begin
                chk("result", 64'(result), 64'(sb[0].r));
                chk("flags", 64'(flags), 64'(sb[0].f));
                if (sb[0].lat) chk("latency", 64'(cyc - sb[0].acc), 64'd4);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input vec_t v, input bit lat);
        int n = 0;
        dataa = v.a;
        datab = v.b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        else sb.push_back('{r: v.r, f: v.f, acc: cyc, lat: lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic half_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input logic [2:0] f);
        int n = 0;
        h_dataa = a;
        h_datab = b;
        h_in_valid = 1'b1;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        @(negedge clk);
        while (!h_out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("h_valid", 64'(h_out_valid), 64'd1);
        chk("h_result", 64'(h_result), 64'(r));
        chk("h_flags", 64'(h_flags), 64'(f));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stale;
        tv[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
        tv[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
        tv[2]  = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000};
        tv[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
        tv[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
        tv[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
        tv[6]  = '{32'hC0000000, 32'h00000000, 32'h80000000, 3'b000};
        tv[7]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
        tv[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000};
        tv[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
        tv[10] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000};
        tv[11] = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000};
        tv[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000};
        tv[13] = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 3'b100};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dataa = '0;
        datab = '0;
        h_in_valid = 1'b0;
        h_out_ready = 1'b1;
        h_dataa = '0;
        h_datab = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) send(tv[i], 1'b1);
        drain();

        // Six ops with a three-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 6; i++) send(tv[i], 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight; none may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            dataa = tv[i].a;
            datab = tv[i].b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("midrst_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;

        half_op(16'h4000, 16'h4200, 16'h4600, 3'b000);
        half_op(16'h3CF7, 16'h3E72, 16'h4000, 3'b000);
        half_op(16'h7800, 16'h7800, 16'h7C00, 3'b010);
        half_op(16'h7C00, 16'h0000, 16'h7E00, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
